// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core memory stage and a
// 4096 x 32-bit single-port SRAM with a 1-cycle registered read.
// One request in flight at a time; responses are single-cycle pulses.
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned accesses
// into error responses with no SRAM access. Without it, the low address
// bits are forced to alignment and the access proceeds.
module riscv_lsu #(
    parameter int AWIDTH = 12,
    parameter int TAGW   = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNS,
    input  logic [31:0]       REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    input  logic [TAGW-1:0]   REQ_TAG,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_DATA,
    output logic [TAGW-1:0]   RSP_TAG,
    output logic              RSP_ERR,
    output logic              D_MEM_CSN,
    output logic              D_MEM_WEN,
    output logic [3:0]        D_MEM_BE,
    output logic [AWIDTH-1:0] D_MEM_ADDR,
    output logic [31:0]       D_MEM_DOUT,
    input  logic [31:0]       D_MEM_DI
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DATA   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Registered copy of the accepted request
    logic [AWIDTH-1:0] addr_q;
    logic [1:0]        lane_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic [TAGW-1:0]   tag_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    // Request decode at the accept edge
    logic       accept;
    logic       req_is_word;
    logic       req_is_half;
    logic       misaligned;
    logic       trap;
    logic [1:0] align_mask;
    logic [1:0] lane_in;

    // Address bits above the SRAM word range do not select anything
    logic unused_addr_hi;
    assign unused_addr_hi = ^REQ_ADDR[31:AWIDTH+2];

    assign accept      = REQ_VALID && (state_q == S_IDLE);
    assign req_is_word = REQ_SIZE[1];
    assign req_is_half = (REQ_SIZE == 2'b01);
    assign misaligned  = (req_is_half && REQ_ADDR[0]) ||
                         (req_is_word && (REQ_ADDR[1:0] != 2'b00));
    // Byte keeps both lane bits, half keeps bit 1, word keeps none
    assign align_mask  = {~req_is_word, ~(req_is_word | req_is_half)};

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap    = misaligned;
    assign lane_in = REQ_ADDR[1:0];
`else
    assign trap    = 1'b0;
    assign lane_in = misaligned ? (REQ_ADDR[1:0] & align_mask) : REQ_ADDR[1:0];
`endif

    // Per-lane store enables and replicated store data
    logic [3:0]  be_lane;
    logic [31:0] dout_rep;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic lane_hit;
        // A lane is written when it falls inside the access footprint
        assign lane_hit = size_q[1] ||
                          (size_q[0] ? (LANE[1] == lane_q[1]) : (LANE == lane_q));
        // Loads always read the full word, so every lane is enabled
        assign be_lane[gi] = we_q ? ~lane_hit : 1'b0;
        // Byte stores repeat byte 0, half stores repeat the low half
        assign dout_rep[8*gi +: 8] = size_q[1] ? wdata_q[8*gi +: 8] :
                                     size_q[0] ? wdata_q[8*(gi%2) +: 8] :
                                                 wdata_q[7:0];
    end

    // Load lane extraction and sign/zero extension
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign ld_byte = D_MEM_DI[{lane_q, 3'b000} +: 8];
    assign ld_half = lane_q[1] ? D_MEM_DI[31:16] : D_MEM_DI[15:0];

    // Extend the selected byte/half according to size and signedness
    always_comb begin
        ld_ext = D_MEM_DI;
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = D_MEM_DI;
        endcase
    end

    // State register, request capture and load result register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lane_q  <= 2'b00;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= REQ_ADDR[AWIDTH+1:2];
                lane_q  <= lane_in;
                we_q    <= REQ_WE;
                size_q  <= REQ_SIZE;
                uns_q   <= REQ_UNS;
                wdata_q <= REQ_WDATA;
                tag_q   <= REQ_TAG;
                err_q   <= trap;
                rdata_q <= '0;
            end else if (state_q == S_DATA) begin
                rdata_q <= ld_ext;
            end
        end
    end

    // Next-state logic and all outputs; memory pins idle outside ACCESS
    always_comb begin
        state_d    = state_q;
        REQ_READY  = 1'b0;
        RSP_VALID  = 1'b0;
        RSP_DATA   = '0;
        RSP_TAG    = '0;
        RSP_ERR    = 1'b0;
        D_MEM_CSN  = 1'b1;
        D_MEM_WEN  = 1'b1;
        D_MEM_BE   = 4'b1111;
        D_MEM_ADDR = '0;
        D_MEM_DOUT = '0;
        case (state_q)
            S_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    state_d = trap ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                D_MEM_CSN  = 1'b0;
                D_MEM_WEN  = ~we_q;
                D_MEM_BE   = be_lane;
                D_MEM_ADDR = addr_q;
                D_MEM_DOUT = dout_rep;
                state_d    = we_q ? S_RESP : S_DATA;
            end
            S_DATA: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                RSP_VALID = 1'b1;
                RSP_DATA  = rdata_q;
                RSP_TAG   = tag_q;
                RSP_ERR   = err_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Testbench for riscv_lsu: behavioural SRAM, byte-addressed reference
// memory, and queue-based scoreboard checked by an independent monitor.
module tb_riscv_lsu;

    localparam int AW = 12;
    localparam int TW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [1:0]    REQ_SIZE = 2'b00;
    logic          REQ_UNS = 1'b0;
    logic [31:0]   REQ_ADDR = '0;
    logic [31:0]   REQ_WDATA = '0;
    logic [TW-1:0] REQ_TAG = '0;
    logic          RSP_VALID;
    logic [31:0]   RSP_DATA;
    logic [TW-1:0] RSP_TAG;
    logic          RSP_ERR;
    logic          D_MEM_CSN;
    logic          D_MEM_WEN;
    logic [3:0]    D_MEM_BE;
    logic [AW-1:0] D_MEM_ADDR;
    logic [31:0]   D_MEM_DOUT;
    logic [31:0]   D_MEM_DI = '0;

    always #5 CLK = ~CLK;

    riscv_lsu #(.AWIDTH(AW), .TAGW(TW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_WE     (REQ_WE),
        .REQ_SIZE   (REQ_SIZE),
        .REQ_UNS    (REQ_UNS),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .REQ_TAG    (REQ_TAG),
        .RSP_VALID  (RSP_VALID),
        .RSP_DATA   (RSP_DATA),
        .RSP_TAG    (RSP_TAG),
        .RSP_ERR    (RSP_ERR),
        .D_MEM_CSN  (D_MEM_CSN),
        .D_MEM_WEN  (D_MEM_WEN),
        .D_MEM_BE   (D_MEM_BE),
        .D_MEM_ADDR (D_MEM_ADDR),
        .D_MEM_DOUT (D_MEM_DOUT),
        .D_MEM_DI   (D_MEM_DI)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] tag;
        logic        err;
        int          acc_cyc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] dout;
    } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    logic [31:0] sram    [0:4095];
    logic [7:0]  ref_mem [0:16383];

    function automatic logic [31:0] initw(input int i);
        return (i * 32'h9E3779B1) ^ 32'hA5C30F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // SRAM model: byte-enabled write, registered read
    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = initw(i);
        forever begin
            @(posedge CLK);
            if (!D_MEM_CSN) begin
                if (!D_MEM_WEN) begin
                    for (int b = 0; b < 4; b++)
                        if (!D_MEM_BE[b]) sram[D_MEM_ADDR][8*b +: 8] = D_MEM_DOUT[8*b +: 8];
                end else begin
                    D_MEM_DI <= sram[D_MEM_ADDR];
                end
            end
        end
    end

    // Monitor: memory access and response checks against the queues
    acc_t mon_a;
    rsp_t mon_r;
    always @(negedge CLK) begin
        if (!RST) begin
            if (!D_MEM_CSN) begin
                chk("ready_busy_acc", {31'd0, REQ_READY}, 32'd0);
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", 32'd1, 32'd0);
                end else begin
                    mon_a = acc_q.pop_front();
                    chk("mem_wen", {31'd0, D_MEM_WEN}, {31'd0, mon_a.wen});
                    chk("mem_be", {28'd0, D_MEM_BE}, {28'd0, mon_a.be});
                    chk("mem_addr", {20'd0, D_MEM_ADDR}, mon_a.addr);
                    if (!mon_a.wen) chk("mem_dout", D_MEM_DOUT, mon_a.dout);
                end
            end
            if (RSP_VALID) begin
                chk("ready_busy_rsp", {31'd0, REQ_READY}, 32'd0);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("rsp_data", RSP_DATA, mon_r.data);
                    chk("rsp_tag", {27'd0, RSP_TAG}, mon_r.tag);
                    chk("rsp_err", {31'd0, RSP_ERR}, {31'd0, mon_r.err});
                    chk("rsp_latency", cyc - mon_r.acc_cyc + 1, mon_r.lat);
                end
            end
        end
    end

    // Reference model: push the expected access and response for a request
    task automatic model_issue(input logic we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [4:0] tag, input bit commit,
                               input bit fixed, input logic [31:0] fixed_data);
        int n, off;
        bit trap;
        logic [31:0] ea, v;
        acc_t a;
        rsp_t r;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (addr % n) != 0;
`else
        trap = 1'b0;
`endif
        ea = addr - (addr % n);
        off = ea % 4;
        r.tag = {27'd0, tag};
        r.acc_cyc = cyc + 1;
        r.data = '0;
        r.err = trap;
        if (trap) begin
            r.lat = 1;
        end else begin
            a.addr = (ea / 4) % 4096;
            a.wen = !we;
            a.be = 4'b0000;
            a.dout = '0;
            for (int i = 0; i < 4; i++) begin
                if (we && !(i >= off && i < off + n)) a.be[i] = 1'b1;
                a.dout[8*i +: 8] = wd[8*(i % n) +: 8];
            end
            acc_q.push_back(a);
            if (we) begin
                r.lat = 2;
                if (commit)
                    for (int k = 0; k < n; k++) ref_mem[(ea + k) % 16384] = wd[8*k +: 8];
            end else begin
                r.lat = 3;
                v = '0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(ea + k) % 16384];
                if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
                r.data = fixed ? fixed_data : v;
            end
        end
        rsp_q.push_back(r);
    endtask

    // Present a request and return right after its accept edge; valid stays high
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] tag, input bit commit,
                          input bit fixed, input logic [31:0] fixed_data);
        int waitc = 0;
        @(negedge CLK);
        REQ_WE = we; REQ_SIZE = sz; REQ_UNS = uns;
        REQ_ADDR = addr; REQ_WDATA = wd; REQ_TAG = tag;
        REQ_VALID = 1'b1;
        while (!REQ_READY) begin
            @(negedge CLK);
            waitc++;
            if (waitc > 20) begin
                chk("ready_timeout", 32'd0, 32'd1);
                REQ_VALID = 1'b0;
                return;
            end
        end
        model_issue(we, sz, uns, addr, wd, tag, commit, fixed, fixed_data);
        @(posedge CLK);
    endtask

    task automatic idle();
        @(negedge CLK);
        REQ_VALID = 1'b0;
        REQ_ADDR = $urandom;
        REQ_WDATA = $urandom;
        REQ_WE = 1'(($urandom_range(0, 1)));
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ready"}, {31'd0, REQ_READY}, 32'd1);
        chk({pfx, "_rsp_valid"}, {31'd0, RSP_VALID}, 32'd0);
        chk({pfx, "_rsp_data"}, RSP_DATA, 32'd0);
        chk({pfx, "_rsp_tag"}, {27'd0, RSP_TAG}, 32'd0);
        chk({pfx, "_rsp_err"}, {31'd0, RSP_ERR}, 32'd0);
        chk({pfx, "_csn"}, {31'd0, D_MEM_CSN}, 32'd1);
        chk({pfx, "_wen"}, {31'd0, D_MEM_WEN}, 32'd1);
        chk({pfx, "_be"}, {28'd0, D_MEM_BE}, 32'hF);
        chk({pfx, "_addr"}, {20'd0, D_MEM_ADDR}, 32'd0);
        chk({pfx, "_dout"}, D_MEM_DOUT, 32'd0);
    endtask

    logic [31:0] w;
    logic [31:0] exp_word;
    int drain;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            w = initw(i);
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end

        @(posedge CLK);
        #1;
        chk_reset_outputs("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Directed sequence with literal expectations
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1, 1'b1, 1'b0, 32'h0); idle();
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 32'hDEADBEEF); idle();
        do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080, 5'd2, 1'b1, 1'b0, 32'h0); idle();
        do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd6, 1'b1, 1'b1, 32'hFFFFFF80); idle();
        do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 32'h00000080); idle();
        do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h00008001, 5'd3, 1'b1, 1'b0, 32'h0); idle();
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 32'hFFFF8001); idle();
        do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 32'h00008001); idle();
        do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd10, 1'b1, 1'b1, 32'h8001BEEF); idle();

        // Back-to-back with REQ_VALID held high
        for (int i = 0; i < 8; i++)
            do_req(1'(i % 2), 2'(i % 4), 1'b0, 32'h140 + 32'(i), $urandom, 5'(i + 11), 1'b1, 1'b0, 32'h0);
        idle();

        // Reset during the ACCESS cycle of a store; the store must not land
        do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, 5'd3, 1'b0, 1'b0, 32'h0);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        REQ_VALID = 1'b0;
        rsp_q.delete();
        acc_q.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        exp_word = initw(32'h80);
        chk("sram_080_kept", sram[12'h080], exp_word);
        do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd4, 1'b1, 1'b0, 32'h0); idle();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom & 32'hFFFFC000) | (32'h100 + $urandom_range(0, 255)),
                   $urandom, 5'($urandom_range(0, 31)), 1'b1, 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        drain = 0;
        while ((rsp_q.size() != 0 || acc_q.size() != 0) && drain < 50) begin
            @(negedge CLK);
            drain++;
        end
        chk("rsp_drain", rsp_q.size(), 32'd0);
        chk("acc_drain", acc_q.size(), 32'd0);

        for (int i = 0; i < 4096; i++) begin
            w = {ref_mem[4*i + 3], ref_mem[4*i + 2], ref_mem[4*i + 1], ref_mem[4*i]};
            if (sram[i] !== w) chk("sram_final", sram[i], w);
        end
        chk("sram_final_0x40", sram[12'h040], {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit between the RISCV_TOP core's memory stage and the D-memory SP_SRAM (4096 x 32-bit, 1-cycle registered read).
- Accepts one load or store request at a time over a valid/ready handshake.
- Generates the word address, active-low byte enables and lane-aligned write data.
- On loads, returns byte/half/word data after lane extraction and sign/zero extension, tagged with the destination register index for RF write-back.

Parameters:
AWIDTH, 12, D-memory word-address width; D_MEM_ADDR = REQ_ADDR[AWIDTH+1:2]
TAGW, 5, width of destination-register tag (matches RF_WA)

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  asynchronous active-high reset
REQ_VALID  in  1  core presents request
REQ_READY  out  1  LSU can accept; request taken when REQ_VALID & REQ_READY at rising edge
REQ_WE  in  1  1 = store, 0 = load
REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 treated as word
REQ_UNS  in  1  load zero-extend (LBU/LHU)
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  store data, LSB-justified
REQ_TAG  in  TAGW  destination register for loads
RSP_VALID  out  1  one-cycle response pulse, no backpressure
RSP_DATA  out  32  extended load data; 0 for stores and errors
RSP_TAG  out  TAGW  tag of the completing request
RSP_ERR  out  1  misaligned access (feature-dependent)
D_MEM_CSN  out  1  SRAM chip select, active-low
D_MEM_WEN  out  1  SRAM write enable, active-low
D_MEM_BE  out  4  byte-lane enables, active-low, bit n = bits [8n+7:8n]
D_MEM_ADDR  out  AWIDTH  SRAM word address
D_MEM_DOUT  out  32  write data to SRAM
D_MEM_DI  in  32  read data from SRAM, valid the cycle after the read edge

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State forced to IDLE.
  - Outputs: REQ_READY=1, RSP_VALID=0, RSP_DATA=0, RSP_TAG=0, RSP_ERR=0, D_MEM_CSN=1, D_MEM_WEN=1, D_MEM_BE=4'b1111, D_MEM_ADDR=0, D_MEM_DOUT=0.
  - An in-flight store that has not reached its SRAM edge must not be written.
- Request capture: ADDR, WE, SIZE, UNS, WDATA and TAG are registered at the accept edge. REQ_READY=1 only in IDLE.
- FSM states:
  - IDLE: on accept, misaligned with trap enabled -> RESP; otherwise -> ACCESS.
  - ACCESS: D_MEM_CSN=0, D_MEM_WEN=~WE, BE/ADDR/DOUT driven from registered request. Store -> RESP; load -> DATA.
  - DATA: CSN=1; D_MEM_DI extracted and extended; result registered -> RESP.
  - RESP: RSP_VALID=1 for exactly one cycle -> IDLE.
- Memory outputs are held at their idle values in every state except ACCESS.
- Latency, counted from the accept edge to RSP_VALID high:
  - Load: 3 cycles. Store: 2 cycles. Trapped misaligned: 1 cycle.
  - Throughput: one request per latency+1 cycles.
- Byte enables (a = addr[1:0]):
  - Byte: BE bit a low.
  - Half: bits {2a[1]+1, 2a[1]} low.
  - Word: 4'b0000.
  - Load: BE=4'b0000 (full word read).
- Store data replication: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word unchanged.
- Load extraction, little-endian:
  - Byte: lane a of D_MEM_DI.
  - Half: half a[1] of D_MEM_DI.
  - Sign-extend from bit 7 or 15 unless UNS=1, in which case zero-extend.
  - Word: UNS ignored.
- Misaligned: half with a[0]=1, or word with a!=0.
- RSP_DATA=0 on store responses. RSP_TAG echoes the request tag for all responses.
- REQ_VALID is ignored outside IDLE. Request inputs may change freely after acceptance.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - A misaligned request performs no SRAM access (CSN stays 1) and goes IDLE -> RESP.
  - The response carries RSP_ERR=1 and RSP_DATA=0.
- Undefined:
  - Low address bits are forced to alignment (half: a[0]=0; word: a=00) and the access proceeds normally.
  - RSP_ERR is tied to 0.

Test Plan:
- Word store then load: SW addr 0x100, data 0xDEADBEEF -> ACCESS cycle shows CSN=0, WEN=0, BE=0000, ADDR=0x040; RSP_VALID 2 cycles after accept. LW 0x100 tag 5 -> RSP_DATA=0xDEADBEEF, RSP_TAG=5, 3 cycles after accept.
- Byte lanes: SB 0x103 data 0x80 -> BE=0111, DOUT=0x80808080. LB 0x103 -> 0xFFFFFF80. LBU 0x103 -> 0x00000080.
- Half: SH 0x102 data 0x8001 -> BE=0011. LH 0x102 -> 0xFFFF8001. LHU -> 0x00008001.
- Misaligned LW 0x101 with LSU_MISALIGN_TRAP_EN -> CSN never low, RSP_ERR=1, RSP_VALID 1 cycle after accept. Without the macro -> reads word 0x100, RSP_ERR=0.
- Back-to-back requests with REQ_VALID held high -> REQ_READY low during ACCESS/DATA/RESP; each request accepted exactly once, responses in order.
- RST asserted during ACCESS of a store to 0x200 -> outputs return to reset values asynchronously, SRAM word 0x080 unchanged, next request completes normally.
